replica_path_monitor: RTL and testbench

Multi-channel critical-path replica monitor for the error-resilient core. Each channel launches a toggling edge every cycle through a tap-selectable delay-line replica of a critical path and captures it one clock later. A late or wrong capture is a timing error. Errors are counted per window and escalated to a sticky alarm that the voltage/frequency controller acknowledges. The block sits beside the pipeline, one channel per replicated path (MMU, ALU, LSU, ...).

---
 rtl/replica_path_monitor.sv | 186 ++++++++++++++++++
 tb/tb_replica_path_monitor.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/replica_path_monitor.sv
// Multi-channel critical-path replica monitor.
// Each channel launches a toggling edge through a tap-selectable chain of
// non-inverting buffer stages and captures it one clock later. Capture
// mismatches (or a forced inject) become error pulses that feed saturating
// window/total counters and a sticky, acknowledgeable alarm.
module replica_path_monitor #(
  parameter int N_CH       = 4,
  parameter int DEPTH      = 128,
  parameter int TAP_W      = 7,
  parameter int CNT_W      = 8,
  parameter int WIN_CYCLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_CH-1:0]         en_i,
  input  logic [N_CH*TAP_W-1:0]   tap_i,
  input  logic [CNT_W-1:0]        thresh_i,
  input  logic [N_CH-1:0]         inject_i,
  input  logic [N_CH-1:0]         alarm_ack_i,
  output logic [N_CH-1:0]         err_o,
  output logic [N_CH-1:0]         alarm_o,
  output logic [N_CH*CNT_W-1:0]   win_cnt_o,
  output logic [N_CH*CNT_W-1:0]   tot_cnt_o,
  output logic [N_CH*2-1:0]       state_o
);

  localparam int               TMR_W    = $clog2(WIN_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WARM = 2'd1,
    ST_MON  = 2'd2
  } state_t;

  logic [TMR_W-1:0] r_winTimer;
  logic             w_winWrap;

  assign w_winWrap = (r_winTimer == TMR_LAST);

  // Shared free-running window timer; its last count marks the wrap edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_winTimer <= '0;
    end else if (w_winWrap) begin
      r_winTimer <= '0;
    end else begin
      r_winTimer <= r_winTimer + TMR_W'(1);
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_t           r_state;
    state_t           w_stateNext;
    logic             r_warmCnt;
    logic             w_warmCntNext;
    logic [TAP_W-1:0] r_tap;
    logic             w_tapChg;
    logic             r_launch;
    logic             w_launchNext;
    logic             r_capture;
    logic             r_expect;
    logic             w_cmpEn;
    logic             w_mismatch;
    logic [DEPTH-1:0] w_taps;
    logic             r_err;
    logic             r_alarm;
    logic             w_alarmSet;
    logic [CNT_W-1:0] r_winCnt;
    logic [CNT_W-1:0] r_totCnt;
    logic [CNT_W-1:0] w_winInc;
    logic [CNT_W-1:0] w_totInc;
    logic [CNT_W-1:0] w_winNext;

    // Replica chain: every stage is a pair of preserved inverters so the
    // physical delay of each tap tracks the real critical path.
    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
      (* dont_touch = "true" *) logic w_inv;
      (* dont_touch = "true" *) logic w_out;
      if (s == 0) begin : g_first
        assign w_inv = ~r_launch;
      end else begin : g_next
        assign w_inv = ~g_stage[s-1].w_out;
      end
      assign w_out     = ~w_inv;
      assign w_taps[s] = w_out;
    end

    assign w_tapChg = (tap_i[c*TAP_W +: TAP_W] != r_tap);

    // Channel FSM state register plus the WARM cycle counter.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_state   <= ST_IDLE;
        r_warmCnt <= 1'b0;
      end else begin
        r_state   <= w_stateNext;
        r_warmCnt <= w_warmCntNext;
      end
    end

    // Next state: disable always wins, a tap change in MON restarts warm-up.
    always_comb begin
      w_stateNext = r_state;
      case (r_state)
        ST_IDLE: if (en_i[c]) w_stateNext = ST_WARM;
        ST_WARM: begin
          if (!en_i[c])      w_stateNext = ST_IDLE;
          else if (r_warmCnt) w_stateNext = ST_MON;
        end
        ST_MON: begin
          if (!en_i[c])     w_stateNext = ST_IDLE;
          else if (w_tapChg) w_stateNext = ST_WARM;
        end
        default: w_stateNext = ST_IDLE;
      endcase
    end

    // FSM outputs: launch toggling, WARM length tracking and compare enable.
    always_comb begin
      w_launchNext  = 1'b0;
      w_warmCntNext = 1'b0;
      w_cmpEn       = 1'b0;
      case (r_state)
        ST_WARM: begin
          w_launchNext  = ~r_launch;
          w_warmCntNext = (w_stateNext == ST_WARM);
        end
        ST_MON: begin
          w_launchNext = ~r_launch;
          w_cmpEn      = 1'b1;
        end
        default: begin
          w_launchNext = 1'b0;
        end
      endcase
    end

    // Launch, capture and expected flops, plus the registered tap select.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_launch  <= 1'b0;
        r_capture <= 1'b0;
        r_expect  <= 1'b0;
        r_tap     <= '0;
      end else begin
        r_launch  <= w_launchNext;
        r_capture <= w_taps[r_tap];
        r_expect  <= r_launch;
        r_tap     <= tap_i[c*TAP_W +: TAP_W];
      end
    end

    assign w_mismatch = w_cmpEn & ((r_capture != r_expect) | inject_i[c]);
    assign w_winInc   = (r_winCnt == CNT_MAX) ? CNT_MAX : r_winCnt + CNT_ONE;
    assign w_totInc   = (r_totCnt == CNT_MAX) ? CNT_MAX : r_totCnt + CNT_ONE;
    assign w_winNext  = w_winWrap  ? (w_mismatch ? CNT_ONE : '0)
                      : w_mismatch ? w_winInc : r_winCnt;
    assign w_alarmSet = w_mismatch & (thresh_i != '0) & (w_winNext >= thresh_i);

    // Error pulse, saturating counters and sticky alarm (set beats ack).
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_err    <= 1'b0;
        r_winCnt <= '0;
        r_totCnt <= '0;
        r_alarm  <= 1'b0;
      end else begin
        r_err    <= w_mismatch;
        r_winCnt <= w_winNext;
        if (w_mismatch) r_totCnt <= w_totInc;
        if (w_alarmSet)          r_alarm <= 1'b1;
        else if (alarm_ack_i[c]) r_alarm <= 1'b0;
      end
    end

    assign err_o[c]                   = r_err;
    assign alarm_o[c]                 = r_alarm;
    assign win_cnt_o[c*CNT_W +: CNT_W] = r_winCnt;
    assign tot_cnt_o[c*CNT_W +: CNT_W] = r_totCnt;
    assign state_o[c*2 +: 2]          = r_state;
  end

endmodule

// File: tb/tb_replica_path_monitor.sv
// Testbench for replica_path_monitor: directed scenarios followed by a
// randomized phase, checked against a behavioural model through a scoreboard.
module tb_replica_path_monitor;

  localparam int N_CH  = 4;
  localparam int TAP_W = 7;
  localparam int CNT_W = 8;
  localparam int WIN   = 1024;
  localparam int SAT   = 255;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic [N_CH-1:0]       en_i;
  logic [N_CH*TAP_W-1:0] tap_i;
  logic [CNT_W-1:0]      thresh_i;
  logic [N_CH-1:0]       inject_i;
  logic [N_CH-1:0]       alarm_ack_i;
  logic [N_CH-1:0]       err_o;
  logic [N_CH-1:0]       alarm_o;
  logic [N_CH*CNT_W-1:0] win_cnt_o;
  logic [N_CH*CNT_W-1:0] tot_cnt_o;
  logic [N_CH*2-1:0]     state_o;

  replica_path_monitor #(
    .N_CH(N_CH), .DEPTH(128), .TAP_W(TAP_W), .CNT_W(CNT_W), .WIN_CYCLES(WIN)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .tap_i(tap_i),
    .thresh_i(thresh_i), .inject_i(inject_i), .alarm_ack_i(alarm_ack_i),
    .err_o(err_o), .alarm_o(alarm_o), .win_cnt_o(win_cnt_o),
    .tot_cnt_o(tot_cnt_o), .state_o(state_o)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct {
    logic [N_CH-1:0]       err;
    logic [N_CH-1:0]       alarm;
    logic [N_CH*CNT_W-1:0] win;
    logic [N_CH*CNT_W-1:0] tot;
    logic [N_CH*2-1:0]     state;
  } expect_t;

  expect_t expQ[$];
  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model: a channel is "active" from the edge its run started;
  // its state is derived from the distance to that edge.
  bit mActive[N_CH];
  int mRunStart[N_CH];
  int mTapReg[N_CH];
  int mWin[N_CH];
  int mTot[N_CH];
  bit mAlarm[N_CH];
  bit mErr[N_CH];
  int mCycles = 0;
  int edgeNo  = 0;

  function automatic int stateAfter(input int c, input int e);
    if (!mActive[c]) return 0;
    return ((e - mRunStart[c]) < 2) ? 1 : 2;
  endfunction

  function automatic int tapOf(input int c);
    return int'(tap_i[c*TAP_W +: TAP_W]);
  endfunction

  task automatic setTap(input int c, input int v);
    tap_i[c*TAP_W +: TAP_W] = TAP_W'(v);
  endtask

  task automatic applyStimulus(input int nCycles);
    repeat (nCycles) begin
      @(posedge clk_i);
      #2;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model process: evaluates the rules at each edge and queues the outputs.
  initial begin
    expect_t x;
    bit wrap;
    bit mis;
    int prevSt;
    forever begin
      @(posedge clk_i);
      edgeNo++;
      if (!rst_ni) begin
        mCycles = 0;
        for (int c = 0; c < N_CH; c++) begin
          mActive[c] = 0; mRunStart[c] = 0; mTapReg[c] = 0;
          mWin[c] = 0; mTot[c] = 0; mAlarm[c] = 0; mErr[c] = 0;
        end
      end else begin
        mCycles++;
        wrap = (mCycles % WIN) == 0;
        for (int c = 0; c < N_CH; c++) begin
          prevSt = stateAfter(c, edgeNo - 1);
          mis = (prevSt == 2) && inject_i[c];
          if (!en_i[c]) mActive[c] = 0;
          else if (prevSt == 0) begin
            mActive[c] = 1; mRunStart[c] = edgeNo;
          end else if (prevSt == 2 && tapOf(c) != mTapReg[c]) mRunStart[c] = edgeNo;
          mTapReg[c] = tapOf(c);
          mErr[c] = mis;
          if (wrap) mWin[c] = mis ? 1 : 0;
          else if (mis) mWin[c] = (mWin[c] + 1 > SAT) ? SAT : mWin[c] + 1;
          if (mis) mTot[c] = (mTot[c] + 1 > SAT) ? SAT : mTot[c] + 1;
          if (mis && thresh_i != 0 && mWin[c] >= int'(thresh_i)) mAlarm[c] = 1;
          else if (alarm_ack_i[c]) mAlarm[c] = 0;
        end
      end
      for (int c = 0; c < N_CH; c++) begin
        x.err[c]                   = mErr[c];
        x.alarm[c]                 = mAlarm[c];
        x.win[c*CNT_W +: CNT_W]    = CNT_W'(mWin[c]);
        x.tot[c*CNT_W +: CNT_W]    = CNT_W'(mTot[c]);
        x.state[c*2 +: 2]          = 2'(stateAfter(c, edgeNo));
      end
      expQ.push_back(x);
    end
  end

  // Monitor process: the DUT presents a full output set every cycle.
  initial begin
    expect_t x;
    forever begin
      @(negedge clk_i);
      if (expQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL scoreboardEmpty at %0t: got 0 entries required 1", $time);
      end else begin
        x = expQ.pop_front();
        checkOutput("err_o",     32'(err_o),     32'(x.err));
        checkOutput("alarm_o",   32'(alarm_o),   32'(x.alarm));
        checkOutput("win_cnt_o", 32'(win_cnt_o), 32'(x.win));
        checkOutput("tot_cnt_o", 32'(tot_cnt_o), 32'(x.tot));
        checkOutput("state_o",   32'(state_o),   32'(x.state));
      end
    end
  end

  // Stimulus process.
  initial begin
    rst_ni = 1'b0; en_i = '1; tap_i = N_CH*TAP_W'($urandom);
    thresh_i = 8'd1; inject_i = '1; alarm_ack_i = '1;
    $display("[TB] reset with all inputs active");
    applyStimulus(6);

    rst_ni = 1'b1; en_i = '0; inject_i = '0; alarm_ack_i = '0; thresh_i = '0;
    for (int c = 0; c < N_CH; c++) setTap(c, 5);
    applyStimulus(8);

    $display("[TB] channel 0 quiet monitoring");
    en_i[0] = 1'b1;
    applyStimulus(2000);

    $display("[TB] channel 1 threshold alarm and ack");
    while ((mCycles % WIN) > WIN - 100) applyStimulus(1);
    en_i[1] = 1'b1; thresh_i = 8'd3;
    applyStimulus(6);
    for (int i = 0; i < 3; i++) begin
      inject_i[1] = 1'b1; applyStimulus(1);
      inject_i[1] = 1'b0; applyStimulus(3);
    end
    alarm_ack_i[1] = 1'b1; applyStimulus(1);
    alarm_ack_i[1] = 1'b0; applyStimulus(3);

    $display("[TB] channel 2 saturation and window wrap");
    thresh_i = '0; en_i[2] = 1'b1;
    applyStimulus(4);
    while ((mCycles % WIN) > WIN - 350) applyStimulus(1);
    inject_i[2] = 1'b1; applyStimulus(300);
    inject_i[2] = 1'b0; applyStimulus(2);
    while (((mCycles + 1) % WIN) != 0) applyStimulus(1);
    inject_i[2] = 1'b1; applyStimulus(1);
    inject_i[2] = 1'b0; applyStimulus(5);

    $display("[TB] channel 3 tap change and disable");
    en_i[3] = 1'b1; inject_i[3] = 1'b1;
    applyStimulus(8);
    setTap(3, 9); applyStimulus(8);
    en_i[3] = 1'b0; applyStimulus(1);
    inject_i[3] = 1'b0; applyStimulus(4);

    $display("[TB] ack coinciding with threshold crossing");
    thresh_i = 8'd2;
    inject_i[1] = 1'b1; applyStimulus(1);
    inject_i[1] = 1'b0; alarm_ack_i[1] = 1'b1; applyStimulus(1);
    alarm_ack_i[1] = 1'b0; applyStimulus(2);
    inject_i[1] = 1'b1; alarm_ack_i[1] = 1'b1; applyStimulus(1);
    inject_i[1] = 1'b0; alarm_ack_i[1] = 1'b0; applyStimulus(3);

    $display("[TB] randomized traffic");
    en_i = '1;
    for (int n = 0; n < 1500; n++) begin
      if (n % 200 == 0) thresh_i = CNT_W'($urandom_range(0, 8));
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 59) == 0) en_i[c] = ~en_i[c];
        if ($urandom_range(0, 39) == 0) setTap(c, int'($urandom_range(0, 127)));
        inject_i[c]    = ($urandom_range(0, 3) == 0);
        alarm_ack_i[c] = ($urandom_range(0, 9) == 0);
      end
      applyStimulus(1);
    end

    $display("[TB] reset in the middle of monitoring");
    en_i = '1; inject_i = '0; alarm_ack_i = '0; thresh_i = 8'd1;
    applyStimulus(5);
    inject_i = '1; applyStimulus(2);
    rst_ni = 1'b0; applyStimulus(1);
    rst_ni = 1'b1; inject_i = '0; en_i = '0;
    applyStimulus(5);

    @(negedge clk_i);
    #1;
    checkOutput("scoreboardDrain", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
